byte_word_packer: RTL and testbench

- Valid/ready stream stage that sits directly downstream of the 8-bit valid proxy stage.
- Consumes 8-bit beats with an end-of-packet flag and packs them little-endian into 32-bit words with a per-byte keep mask.
- Presents the packed words on a registered valid/ready output toward the word-wide datapath.
- Sustains one byte per cycle with no bubbles under continuous down_ready.

---
 rtl/byte_word_packer.sv | 123 ++++++++++++
 tb/tb_byte_word_packer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/byte_word_packer.sv
// byte_word_packer: valid/ready stage packing BYTE_W-bit beats little-endian
// into LANES-beat words with a per-byte keep mask and end-of-packet flag.
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   up_data/up_valid/up_last/up_ready        input byte stream
//   down_data/down_keep/down_last/down_valid/down_ready  registered word stream
//   pkt_cnt               packets delivered downstream (wraps)
//
// Throughput: up_ready depends only on the output register, so one byte per
// cycle is sustained while down_ready stays high, and a completing word may
// replace the word being drained on the same edge.

// One accumulator lane: holds a byte and its keep bit until the word completes.
module byte_word_packer_lane #(
  parameter int BYTE_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr,      // byte for this lane accepted this cycle
  input  logic              clr,     // word completes this cycle
  input  logic [BYTE_W-1:0] din,
  output logic [BYTE_W-1:0] word,    // lane content as it leaves on completion
  output logic              keep
);
  logic [BYTE_W-1:0] acc;
  logic              acc_keep;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc      <= '0;
      acc_keep <= 1'b0;
    end else if (clr) begin
      acc      <= '0;
      acc_keep <= 1'b0;
    end else if (wr) begin
      acc      <= din;
      acc_keep <= 1'b1;
    end
  end

  // Completing beat bypasses the accumulator; untouched lanes above it are
  // still at their cleared value, so they leave as 0 with keep=0.
  assign word = wr ? din : acc;
  assign keep = wr | acc_keep;
endmodule

module byte_word_packer #(
  parameter int BYTE_W = 8,
  parameter int LANES  = 4,
  parameter int CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [BYTE_W-1:0]       up_data,
  input  logic                    up_valid,
  input  logic                    up_last,
  output logic                    up_ready,
  output logic [BYTE_W*LANES-1:0] down_data,
  output logic [LANES-1:0]        down_keep,
  output logic                    down_last,
  output logic                    down_valid,
  input  logic                    down_ready,
  output logic [CNT_W-1:0]        pkt_cnt
);
  localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;

  logic [IDX_W-1:0]              lane_idx;
  logic                          up_fire, down_fire, complete;
  logic [LANES-1:0]              lane_wr, nxt_keep;
  logic [LANES-1:0][BYTE_W-1:0]  nxt_data;

  assign up_ready  = !down_valid || down_ready;
  assign up_fire   = up_valid && up_ready;
  assign down_fire = down_valid && down_ready;
  assign complete  = up_fire && (up_last || lane_idx == IDX_W'(LANES-1));

  genvar i;
  generate
    for (i = 0; i < LANES; i++) begin : g_lane
      assign lane_wr[i] = up_fire && (lane_idx == IDX_W'(i));
      byte_word_packer_lane #(.BYTE_W(BYTE_W)) u_lane (
        .clk  (clk),
        .rst_n(rst_n),
        .wr   (lane_wr[i]),
        .clr  (complete),
        .din  (up_data),
        .word (nxt_data[i]),
        .keep (nxt_keep[i])
      );
    end
  endgenerate

  // Explicit clear on completion keeps non-power-of-2 LANES correct.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        lane_idx <= '0;
    else if (complete) lane_idx <= '0;
    else if (up_fire)  lane_idx <= lane_idx + IDX_W'(1);
  end

  // Output register: a completing word wins over draining, giving zero-bubble
  // replacement when down_fire and completion coincide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      down_valid <= 1'b0;
      down_data  <= '0;
      down_keep  <= '0;
      down_last  <= 1'b0;
    end else if (complete) begin
      down_valid <= 1'b1;
      down_data  <= nxt_data;
      down_keep  <= nxt_keep;
      down_last  <= up_last;
    end else if (down_fire) begin
      down_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      pkt_cnt <= '0;
    else if (down_fire && down_last) pkt_cnt <= pkt_cnt + CNT_W'(1);
  end
endmodule

// File: tb/tb_byte_word_packer.sv
// Scoreboard bench for byte_word_packer: stimulus pushes expected words into
// a queue; a monitor pops and compares on every output handshake.
module tb_byte_word_packer;
  logic        clk, rst_n;
  logic [7:0]  up_data;
  logic        up_valid, up_last, up_ready;
  logic [31:0] down_data;
  logic [3:0]  down_keep;
  logic        down_last, down_valid, down_ready;
  logic [15:0] pkt_cnt;

  byte_word_packer dut (
    .clk(clk), .rst_n(rst_n),
    .up_data(up_data), .up_valid(up_valid), .up_last(up_last), .up_ready(up_ready),
    .down_data(down_data), .down_keep(down_keep), .down_last(down_last),
    .down_valid(down_valid), .down_ready(down_ready), .pkt_cnt(pkt_cnt)
  );

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
  } exp_t;

  exp_t q[$];
  int total = 0, bad = 0, stalls = 0;
  int exp_pkts = 0;
  logic rdy_mode = 1'b0, rdy_fix = 1'b1;

  // reference packer for the random stream
  logic [31:0] m_acc = '0;
  logic [3:0]  m_keep = '0;
  int          m_lane = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) down_ready = rdy_mode ? ($urandom_range(0, 3) != 0) : rdy_fix;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Monitor: at this point every input for the coming edge is settled.
  always @(negedge clk) begin : mon
    exp_t e;
    #2;
    if (rst_n && down_valid && down_ready) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL pop_empty: got %h/%h/%b want nothing", down_data, down_keep, down_last);
      end else begin
        e = q.pop_front();
        if ({down_data, down_keep, down_last} !== e) begin
          bad++;
          $display("FAIL word: got %h keep %h last %b want %h keep %h last %b",
                   down_data, down_keep, down_last, e.d, e.k, e.l);
        end
      end
    end
  end

  task automatic expect_word(input logic [31:0] d, input logic [3:0] k, input logic l);
    q.push_back({d, k, l});
    if (l) exp_pkts++;
  endtask

  task automatic model_byte(input logic [7:0] d, input logic l);
    m_acc[m_lane*8 +: 8] = d;
    m_keep[m_lane] = 1'b1;
    if (m_lane == 3 || l) begin
      expect_word(m_acc, m_keep, l);
      m_acc = '0; m_keep = '0; m_lane = 0;
    end else m_lane++;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic l, input int gap);
    int n;
    repeat (gap) begin
      @(negedge clk);
      up_valid = 1'b0; up_data = 8'($urandom); up_last = 1'($urandom);
    end
    @(negedge clk);
    up_valid = 1'b1; up_data = d; up_last = l;
    n = 0;
    #1;
    while (!up_ready) begin
      @(negedge clk); #1;
      n++; stalls++;
      if (n > 1000) begin
        $display("FAIL up_ready_timeout: got 0 want 1");
        $fatal(1, "stalled");
      end
    end
    @(posedge clk);
  endtask

  task automatic idle();
    @(negedge clk);
    up_valid = 1'b0; up_last = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (n < 500) begin
      @(negedge clk); #3;
      if (q.size() == 0 && !down_valid) break;
      n++;
    end
    chk({name, "_drain"}, 64'(n < 500), 64'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    q.delete(); exp_pkts = 0;
    m_acc = '0; m_keep = '0; m_lane = 0;
    @(negedge clk); #1;
    chk("rst_valid", 64'(down_valid), 64'd0);
    chk("rst_data",  64'(down_data),  64'd0);
    chk("rst_keep",  64'(down_keep),  64'd0);
    chk("rst_last",  64'(down_last),  64'd0);
    chk("rst_cnt",   64'(pkt_cnt),    64'd0);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; up_valid = 1'b0; up_data = '0; up_last = 1'b0; down_ready = 1'b0;
    repeat (3) @(negedge clk);
    do_reset();

    // continuous stream, no stalls expected
    rdy_mode = 1'b0; rdy_fix = 1'b1; stalls = 0;
    expect_word(32'h03020100, 4'hF, 1'b0);
    expect_word(32'h07060504, 4'hF, 1'b1);
    for (int i = 0; i < 8; i++) send_byte(8'(i), i == 7, 0);
    idle();
    drain("cont");
    chk("cont_stalls", 64'(stalls), 64'd0);
    chk("cont_cnt", 64'(pkt_cnt), 64'(exp_pkts));

    // short packets
    expect_word(32'h000000AA, 4'h1, 1'b1);
    expect_word(32'h0000B1B0, 4'h3, 1'b1);
    send_byte(8'hAA, 1'b1, 0);
    send_byte(8'hB0, 1'b0, 0);
    send_byte(8'hB1, 1'b1, 0);
    idle();
    drain("short");
    chk("short_cnt", 64'(pkt_cnt), 64'(exp_pkts));

    // backpressure: word held for 5 cycles, following bytes wait
    rdy_fix = 1'b0;
    expect_word(32'hC3C2C1C0, 4'hF, 1'b0);
    expect_word(32'h0000C5C4, 4'h3, 1'b1);
    fork
      begin
        for (int i = 0; i < 4; i++) send_byte(8'hC0 + 8'(i), 1'b0, 0);
        send_byte(8'hC4, 1'b0, 0);
        send_byte(8'hC5, 1'b1, 0);
        idle();
      end
      begin
        int n;
        n = 0;
        while (!down_valid && n < 100) begin @(negedge clk); n++; end
        chk("bp_valid", 64'(down_valid), 64'd1);
        repeat (5) begin
          @(negedge clk); #2;
          chk("bp_hold", {31'd0, up_ready, down_data, down_keep, down_last},
              {31'd0, 1'b0, 32'hC3C2C1C0, 4'hF, 1'b0});
        end
        rdy_fix = 1'b1;
      end
    join
    drain("bp");
    chk("bp_cnt", 64'(pkt_cnt), 64'(exp_pkts));

    // random valid/ready, ~2000 bytes, packets of 1..9 bytes
    rdy_mode = 1'b1;
    begin
      int sent;
      sent = 0;
      while (sent < 2000) begin
        int len;
        len = $urandom_range(1, 9);
        for (int j = 0; j < len; j++) begin
          logic [7:0] d;
          d = 8'($urandom);
          model_byte(d, j == len - 1);
          send_byte(d, j == len - 1, ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0);
        end
        sent += len;
      end
    end
    idle();
    rdy_mode = 1'b0; rdy_fix = 1'b1;
    drain("rand");
    chk("rand_cnt", 64'(pkt_cnt), 64'(exp_pkts));

    // reset mid-packet discards partial bytes
    send_byte(8'h11, 1'b0, 0);
    send_byte(8'h22, 1'b0, 0);
    idle();
    do_reset();
    expect_word(32'h36353433, 4'hF, 1'b1);
    for (int i = 0; i < 4; i++) send_byte(8'h33 + 8'(i), i == 3, 0);
    idle();
    drain("rstmid");
    chk("rstmid_cnt", 64'(pkt_cnt), 64'd1);

    // counter wrap
    do_reset();
    for (int i = 0; i < 65535; i++) begin
      expect_word({24'd0, 8'(i)}, 4'h1, 1'b1);
      send_byte(8'(i), 1'b1, 0);
    end
    idle();
    drain("wrap_pre");
    chk("wrap_max", 64'(pkt_cnt), 64'hFFFF);
    expect_word(32'h0000005A, 4'h1, 1'b1);
    send_byte(8'h5A, 1'b1, 0);
    idle();
    drain("wrap");
    chk("wrap_zero", 64'(pkt_cnt), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
